// File: rtl/alu_issue.sv
// Issue/writeback front end for the 16-bit ALU: decodes, reads the 8x16
// register file with EX->decode bypass, and retires ALU results one cycle later.
module alu_issue #(
  parameter logic [15:0] BUBBLE = 16'h0800,
  parameter int          CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [15:0]      in_instruction,
  output logic             in_ready,
  input  logic             stall,
  output logic [15:0]      alu_rx,
  output logic [15:0]      alu_ry,
  output logic [15:0]      alu_instruction,
  input  logic [15:0]      alu_res,
  input  logic             alu_t_written,
  input  logic             alu_t,
  output logic             t_flag,
  input  logic [2:0]       dbg_sel,
  output logic [15:0]      dbg_data,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    DK_NONE = 2'd0,
    DK_REG  = 2'd1,
    DK_T    = 2'd2
  } dest_kind_t;

  typedef enum logic [1:0] {
    BS_ZERO = 2'd0,
    BS_REG  = 2'd1,
    BS_IMM  = 2'd2
  } b_src_t;

  logic [15:0]      r_regs [0:7];
  logic [15:0]      r_rx;
  logic [15:0]      r_ry;
  logic [15:0]      r_ins;
  logic             r_t;
  logic             r_ex_valid;
  dest_kind_t       r_ex_dk;
  logic [2:0]       r_ex_didx;
  logic [CNT_W-1:0] r_retired;

  logic [4:0]  w_op;
  logic [4:0]  w_funct;
  logic [2:0]  w_x;
  logic [2:0]  w_y;
  logic [7:0]  w_imm8;
  logic        w_a_en;
  logic [2:0]  w_a_idx;
  b_src_t      w_b_src;
  dest_kind_t  w_dk;
  logic [2:0]  w_didx;
  logic [15:0] w_rd_a;
  logic [15:0] w_rd_b;
  logic [15:0] w_op_a;
  logic [15:0] w_op_b;
  logic        w_unused_ok;

  assign w_op    = in_instruction[15:11];
  assign w_x     = in_instruction[10:8];
  assign w_y     = in_instruction[7:5];
  assign w_imm8  = in_instruction[7:0];
  assign w_funct = in_instruction[4:0];

  assign in_ready        = ~stall;
  assign alu_rx          = r_rx;
  assign alu_ry          = r_ry;
  assign alu_instruction = r_ins;
  assign t_flag          = r_t;
  assign retired         = r_retired;
  assign dbg_data        = r_regs[dbg_sel];

  // The T-write strobe is informational only; T writeback follows decode.
  assign w_unused_ok = &{1'b0, alu_t_written};

  // Instruction decode: operand sources and destination selection.
  always_comb begin
    w_a_en  = 1'b0;
    w_a_idx = w_x;
    w_b_src = BS_ZERO;
    w_dk    = DK_NONE;
    w_didx  = w_x;
    case (w_op)
      5'b00110: begin
        w_a_en  = 1'b1;
        w_a_idx = w_y;
        w_dk    = DK_REG;
      end
      5'b01001: begin
        w_a_en = 1'b1;
        w_dk   = DK_REG;
      end
      5'b01010, 5'b01110: begin
        w_a_en = 1'b1;
        w_dk   = DK_T;
      end
      5'b01011: begin
        w_a_en  = 1'b1;
        w_b_src = BS_IMM;
        w_dk    = DK_T;
      end
      5'b11100: begin
        w_a_en  = 1'b1;
        w_b_src = BS_REG;
        w_dk    = DK_REG;
        w_didx  = in_instruction[4:2];
      end
      5'b11101: begin
        case (w_funct)
          5'b00010, 5'b00011, 5'b01010: begin
            w_a_en  = 1'b1;
            w_b_src = BS_REG;
            w_dk    = DK_T;
          end
          5'b00100, 5'b00110, 5'b00111, 5'b01011,
          5'b01100, 5'b01101, 5'b01110, 5'b01111: begin
            w_a_en  = 1'b1;
            w_b_src = BS_REG;
            w_dk    = DK_REG;
          end
          default: begin
            w_a_en  = 1'b0;
            w_b_src = BS_ZERO;
            w_dk    = DK_NONE;
          end
        endcase
      end
      default: begin
        w_a_en  = 1'b0;
        w_b_src = BS_ZERO;
        w_dk    = DK_NONE;
      end
    endcase
  end

  // Register read with forwarding of the result retiring on this edge.
  always_comb begin
    if (r_ex_valid && (r_ex_dk == DK_REG) && (r_ex_didx == w_a_idx)) begin
      w_rd_a = alu_res;
    end else begin
      w_rd_a = r_regs[w_a_idx];
    end
    if (r_ex_valid && (r_ex_dk == DK_REG) && (r_ex_didx == w_y)) begin
      w_rd_b = alu_res;
    end else begin
      w_rd_b = r_regs[w_y];
    end
    if (w_a_en) begin
      w_op_a = w_rd_a;
    end else begin
      w_op_a = 16'h0000;
    end
    case (w_b_src)
      BS_REG:  w_op_b = w_rd_b;
      BS_IMM:  w_op_b = {8'h00, w_imm8};
      default: w_op_b = 16'h0000;
    endcase
  end

  // EX stage, writeback into register file / T, and retirement counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= 16'h0000;
      end
      r_rx       <= 16'h0000;
      r_ry       <= 16'h0000;
      r_ins      <= BUBBLE;
      r_t        <= 1'b0;
      r_ex_valid <= 1'b0;
      r_ex_dk    <= DK_NONE;
      r_ex_didx  <= 3'd0;
      r_retired  <= {CNT_W{1'b0}};
    end else if (!stall) begin
      if (r_ex_valid) begin
        case (r_ex_dk)
          DK_REG: begin
            r_regs[r_ex_didx] <= alu_res;
            r_retired         <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          DK_T: begin
            r_t       <= alu_t;
            r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          default: begin
            r_retired <= r_retired;
          end
        endcase
      end
      if (in_valid) begin
        r_rx       <= w_op_a;
        r_ry       <= w_op_b;
        r_ins      <= in_instruction;
        r_ex_valid <= 1'b1;
        r_ex_dk    <= w_dk;
        r_ex_didx  <= w_didx;
      end else begin
        r_rx       <= 16'h0000;
        r_ry       <= 16'h0000;
        r_ins      <= BUBBLE;
        r_ex_valid <= 1'b0;
        r_ex_dk    <= DK_NONE;
        r_ex_didx  <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed vector table plus randomized traffic checked
// against an in-order architectural model with a stand-in ALU.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_instruction;
  logic        in_ready;
  logic        stall;
  logic [15:0] alu_rx, alu_ry, alu_instruction, alu_res;
  logic        alu_t_written, alu_t, t_flag;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  alu_issue #(.BUBBLE(16'h0800), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instruction(in_instruction),
    .in_ready(in_ready), .stall(stall), .alu_rx(alu_rx), .alu_ry(alu_ry),
    .alu_instruction(alu_instruction), .alu_res(alu_res),
    .alu_t_written(alu_t_written), .alu_t(alu_t), .t_flag(t_flag),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .retired(retired)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: returns {t_written, t, res}.
  function automatic logic [17:0] alu_f(input logic [15:0] ins, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] sx;
    logic [4:0]  f;
    sx = {{8{ins[7]}}, ins[7:0]};
    f  = ins[4:0];
    case (ins[15:11])
      5'b00110: alu_f = {2'b00, a << 1};
      5'b01001: alu_f = {2'b00, a + sx};
      5'b01010: alu_f = {1'b1, $signed(a) < $signed(sx), 16'h0000};
      5'b01011: alu_f = {1'b1, a < b, 16'h0000};
      5'b01110: alu_f = {1'b1, a != sx, 16'h0000};
      5'b11100: alu_f = {2'b00, (ins[1:0] == 2'b11) ? a - b : a + b};
      5'b11101: begin
        if (f == 5'd2)       alu_f = {1'b1, $signed(a) < $signed(b), 16'h0000};
        else if (f == 5'd3)  alu_f = {1'b1, a < b, 16'h0000};
        else if (f == 5'd10) alu_f = {1'b1, a != b, 16'h0000};
        else                 alu_f = {2'b00, (a ^ b) + {11'd0, f}};
      end
      default: alu_f = 18'd0;
    endcase
  endfunction

  always_comb {alu_t_written, alu_t, alu_res} = alu_f(alu_instruction, alu_rx, alu_ry);

  // Architectural model: retire the older instruction first, then decode the new one.
  logic [15:0] m_reg [8];
  logic        m_t;
  logic [15:0] m_ret;
  logic        p_valid;
  int          p_kind;   // 0 none, 1 register, 2 T
  logic [2:0]  p_idx;
  logic [15:0] p_a, p_b, p_ins;

  task automatic model_decode(input logic [15:0] ins);
    logic [2:0] x, y;
    logic [4:0] f;
    x = ins[10:8]; y = ins[7:5]; f = ins[4:0];
    p_a = 16'h0000; p_b = 16'h0000; p_kind = 0; p_idx = x;
    case (ins[15:11])
      5'b00110: begin p_a = m_reg[y]; p_kind = 1; end
      5'b01001: begin p_a = m_reg[x]; p_kind = 1; end
      5'b01010, 5'b01110: begin p_a = m_reg[x]; p_kind = 2; end
      5'b01011: begin p_a = m_reg[x]; p_b = {8'h00, ins[7:0]}; p_kind = 2; end
      5'b11100: begin p_a = m_reg[x]; p_b = m_reg[y]; p_kind = 1; p_idx = ins[4:2]; end
      5'b11101: begin
        if (f == 5'd2 || f == 5'd3 || f == 5'd10) begin
          p_a = m_reg[x]; p_b = m_reg[y]; p_kind = 2;
        end else if (f == 5'd4 || f == 5'd6 || f == 5'd7 || (f >= 5'd11 && f <= 5'd15)) begin
          p_a = m_reg[x]; p_b = m_reg[y]; p_kind = 1;
        end
      end
      default: p_kind = 0;
    endcase
  endtask

  task automatic model_update(input logic r, input logic v, input logic [15:0] ins, input logic st);
    logic [17:0] o;
    if (r) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
      m_t = 1'b0; m_ret = 16'h0000;
      p_valid = 1'b0; p_kind = 0; p_idx = 3'd0; p_a = 16'h0000; p_b = 16'h0000; p_ins = 16'h0800;
    end else if (!st) begin
      if (p_valid) begin
        o = alu_f(p_ins, p_a, p_b);
        if (p_kind == 1) begin m_reg[p_idx] = o[15:0]; m_ret = m_ret + 16'd1; end
        if (p_kind == 2) begin m_t = o[16]; m_ret = m_ret + 16'd1; end
      end
      if (v) begin
        model_decode(ins);
        p_valid = 1'b1; p_ins = ins;
      end else begin
        p_valid = 1'b0; p_kind = 0; p_a = 16'h0000; p_b = 16'h0000; p_ins = 16'h0800;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [15:0] ins, input logic st, input logic [2:0] sel);
    @(negedge clk);
    rst = r; in_valid = v; in_instruction = ins; stall = st; dbg_sel = sel;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, ~st});
    model_update(r, v, ins, st);
    @(posedge clk);
    #1;
    chk("model_rx",  {16'd0, alu_rx}, {16'd0, p_a});
    chk("model_ry",  {16'd0, alu_ry}, {16'd0, p_b});
    chk("model_ins", {16'd0, alu_instruction}, {16'd0, p_ins});
    chk("model_t",   {31'd0, t_flag}, {31'd0, m_t});
    chk("model_ret", {16'd0, retired}, {16'd0, m_ret});
    chk("model_dbg", {16'd0, dbg_data}, {16'd0, m_reg[sel]});
  endtask

  typedef struct {
    logic        r;
    logic        v;
    logic [15:0] ins;
    logic        st;
    logic [2:0]  sel;
    logic [15:0] e_rx;
    logic [15:0] e_ins;
    logic        e_t;
    logic [15:0] e_ret;
    logic [15:0] e_dbg;
  } vec_t;

  vec_t vecs [21];

  function automatic logic [15:0] rand_instr();
    logic [4:0]  ops [8];
    logic [4:0]  fns [12];
    logic [31:0] rv;
    logic [15:0] w;
    ops = '{5'b00110, 5'b01001, 5'b01010, 5'b01011, 5'b01110, 5'b11100, 5'b11101, 5'b10010};
    fns = '{5'd2, 5'd3, 5'd10, 5'd4, 5'd6, 5'd7, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
    rv = $urandom();
    w  = rv[15:0];
    w[15:11] = ops[$urandom_range(0, 7)];
    if ($urandom_range(0, 9) == 0) w[15:11] = rv[31:27];
    if (w[15:11] == 5'b11101) w[4:0] = fns[$urandom_range(0, 11)];
    return w;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instruction = 16'h0000; stall = 1'b0; dbg_sel = 3'd0;
    model_update(1'b1, 1'b0, 16'h0000, 1'b0);

    //          r     v     ins       st    sel   e_rx      e_ins     e_t   e_ret     e_dbg
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h0800, 1'b0, 16'd0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h0800, 1'b0, 16'd0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 16'h4905, 1'b0, 3'd1, 16'h0000, 16'h4905, 1'b0, 16'd0, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 16'h4903, 1'b0, 3'd1, 16'h0005, 16'h4903, 1'b0, 16'd1, 16'h0005};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 3'd1, 16'h0000, 16'h0800, 1'b0, 16'd2, 16'h0008};
    vecs[5]  = '{1'b0, 1'b1, 16'h4A07, 1'b0, 3'd1, 16'h0000, 16'h4A07, 1'b0, 16'd2, 16'h0008};
    vecs[6]  = '{1'b0, 1'b1, 16'h4B07, 1'b0, 3'd2, 16'h0000, 16'h4B07, 1'b0, 16'd3, 16'h0007};
    vecs[7]  = '{1'b0, 1'b1, 16'hEA6A, 1'b0, 3'd3, 16'h0007, 16'hEA6A, 1'b0, 16'd4, 16'h0007};
    vecs[8]  = '{1'b0, 1'b1, 16'h7201, 1'b0, 3'd2, 16'h0007, 16'h7201, 1'b0, 16'd5, 16'h0007};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 3'd3, 16'h0000, 16'h0800, 1'b1, 16'd6, 16'h0007};
    vecs[10] = '{1'b0, 1'b1, 16'hE131, 1'b0, 3'd4, 16'h0008, 16'hE131, 1'b1, 16'd6, 16'h0000};
    vecs[11] = '{1'b0, 1'b1, 16'h4905, 1'b1, 3'd4, 16'h0008, 16'hE131, 1'b1, 16'd6, 16'h0000};
    vecs[12] = '{1'b0, 1'b1, 16'h4905, 1'b1, 3'd4, 16'h0008, 16'hE131, 1'b1, 16'd6, 16'h0000};
    vecs[13] = '{1'b0, 1'b1, 16'h4905, 1'b1, 3'd4, 16'h0008, 16'hE131, 1'b1, 16'd6, 16'h0000};
    vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 3'd4, 16'h0000, 16'h0800, 1'b1, 16'd7, 16'h0010};
    vecs[15] = '{1'b0, 1'b1, 16'h0800, 1'b0, 3'd1, 16'h0000, 16'h0800, 1'b1, 16'd7, 16'h0008};
    vecs[16] = '{1'b0, 1'b1, 16'h9000, 1'b0, 3'd2, 16'h0000, 16'h9000, 1'b1, 16'd7, 16'h0007};
    vecs[17] = '{1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h0800, 1'b1, 16'd7, 16'h0000};
    vecs[18] = '{1'b0, 1'b1, 16'h4D01, 1'b0, 3'd5, 16'h0000, 16'h4D01, 1'b1, 16'd7, 16'h0000};
    vecs[19] = '{1'b1, 1'b0, 16'h0000, 1'b0, 3'd5, 16'h0000, 16'h0800, 1'b0, 16'd0, 16'h0000};
    vecs[20] = '{1'b0, 1'b0, 16'h0000, 1'b0, 3'd5, 16'h0000, 16'h0800, 1'b0, 16'd0, 16'h0000};

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].r, vecs[i].v, vecs[i].ins, vecs[i].st, vecs[i].sel);
      chk($sformatf("vec%0d_rx", i),  {16'd0, alu_rx}, {16'd0, vecs[i].e_rx});
      chk($sformatf("vec%0d_ins", i), {16'd0, alu_instruction}, {16'd0, vecs[i].e_ins});
      chk($sformatf("vec%0d_t", i),   {31'd0, t_flag}, {31'd0, vecs[i].e_t});
      chk($sformatf("vec%0d_ret", i), {16'd0, retired}, {16'd0, vecs[i].e_ret});
      chk($sformatf("vec%0d_dbg", i), {16'd0, dbg_data}, {16'd0, vecs[i].e_dbg});
    end

    // Back-to-back dependents on both operands, including a stalled producer.
    step(1'b0, 1'b1, 16'h4A03, 1'b0, 3'd2);
    step(1'b0, 1'b1, 16'hE24C, 1'b0, 3'd2);
    step(1'b0, 1'b1, 16'hE24C, 1'b1, 3'd2);
    step(1'b0, 1'b1, 16'hE24C, 1'b0, 3'd2);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 3'd3);

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, rand_instr(),
           $urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
